// File: rtl/seq_tx.sv
// Serial pattern transmitter: shifts a loadable bit pattern out LSB first with a companion clock.
// Optional SEQ_TX_REPEAT_EN restarts the frame back to back while start is held at the frame end.
module seq_tx #(
    parameter int MAX_LEN = 64,
    parameter int DIV     = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] load_data,
    input  logic [6:0] length,
    input  logic       start,
    output logic       dataout,
    output logic       clkout,
    output logic       busy,
    output logic       done
);

    localparam int NBYTES = MAX_LEN / 8;
    localparam int WPTR_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int BIDX_W = $clog2(MAX_LEN);
    localparam int CNT_W  = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [6:0]        LEN_MAX   = 7'(MAX_LEN);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DIV - 1);
    localparam logic [WPTR_W-1:0] WPTR_LAST = WPTR_W'(NBYTES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_HIGH  = 2'd2
    } state_t;

    state_t              state_r, state_s;
    logic [BIDX_W-1:0]   bidx_r, bidx_s;
    logic [BIDX_W-1:0]   last_r, last_s;
    logic [CNT_W-1:0]    cnt_r, cnt_s;
    logic [MAX_LEN-1:0]  pat_r;
    logic [WPTR_W-1:0]   wptr_r;
    logic                frame_end_s;
    logic                load_ok_s;
    logic                rpt_s;
    logic                dataout_r, clkout_r, busy_r, done_r;
    logic                dataout_s, clkout_s, busy_s, done_s;

`ifdef SEQ_TX_REPEAT_EN
    assign rpt_s = start;
`else
    assign rpt_s = 1'b0;
`endif

    // Loads are only accepted between frames so the pattern is stable while shifting.
    assign load_ok_s = load && (state_r == ST_IDLE);

    // State register: FSM state, bit index, latched last-bit index and phase counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
            bidx_r  <= '0;
            last_r  <= '0;
            cnt_r   <= '0;
        end else begin
            state_r <= state_s;
            bidx_r  <= bidx_s;
            last_r  <= last_s;
            cnt_r   <= cnt_s;
        end
    end

    // Next-state logic: frame acceptance, half-bit timing and end-of-frame decision.
    always_comb begin
        state_s     = state_r;
        bidx_s      = bidx_r;
        last_s      = last_r;
        cnt_s       = cnt_r;
        frame_end_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start && (length != 7'd0) && (length <= LEN_MAX)) begin
                    state_s = ST_SETUP;
                    bidx_s  = '0;
                    last_s  = BIDX_W'(length - 7'd1);
                    cnt_s   = '0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (cnt_r == CNT_LAST) begin
                    state_s = ST_HIGH;
                    cnt_s   = '0;
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            ST_HIGH: begin
                if (cnt_r == CNT_LAST) begin
                    cnt_s = '0;
                    if (bidx_r != last_r) begin
                        bidx_s  = bidx_r + BIDX_W'(1);
                        state_s = ST_SETUP;
                    end else if (rpt_s) begin
                        bidx_s  = '0;
                        state_s = ST_SETUP;
                    end else begin
                        bidx_s      = '0;
                        state_s     = ST_IDLE;
                        frame_end_s = 1'b1;
                    end
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            default: begin
                state_s = ST_IDLE;
                bidx_s  = '0;
                cnt_s   = '0;
            end
        endcase
    end

    // Output decode from the next state so the registered pins line up with the state change.
    always_comb begin
        dataout_s = 1'b0;
        clkout_s  = 1'b0;
        busy_s    = 1'b0;
        done_s    = frame_end_s;
        case (state_s)
            ST_IDLE: begin
                dataout_s = 1'b0;
                clkout_s  = 1'b0;
                busy_s    = 1'b0;
            end
            ST_SETUP: begin
                dataout_s = pat_r[bidx_s];
                clkout_s  = 1'b0;
                busy_s    = 1'b1;
            end
            ST_HIGH: begin
                dataout_s = pat_r[bidx_s];
                clkout_s  = 1'b1;
                busy_s    = 1'b1;
            end
            default: begin
                dataout_s = 1'b0;
                clkout_s  = 1'b0;
                busy_s    = 1'b0;
            end
        endcase
    end

    // Output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dataout_r <= 1'b0;
            clkout_r  <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            dataout_r <= dataout_s;
            clkout_r  <= clkout_s;
            busy_r    <= busy_s;
            done_r    <= done_s;
        end
    end

    // Pattern buffer byte writes.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pat_r <= '0;
        end else if (load_ok_s) begin
            pat_r[{wptr_r, 3'b000} +: 8] <= load_data;
        end else begin
            pat_r <= pat_r;
        end
    end

    // Write pointer: advances per accepted byte, rewinds when a frame finishes.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wptr_r <= '0;
        end else if (frame_end_s) begin
            wptr_r <= '0;
        end else if (load_ok_s) begin
            wptr_r <= (wptr_r == WPTR_LAST) ? '0 : wptr_r + WPTR_W'(1);
        end else begin
            wptr_r <= wptr_r;
        end
    end

    assign dataout = dataout_r;
    assign clkout  = clkout_r;
    assign busy    = busy_r;
    assign done    = done_r;

endmodule

// File: tb/tb_seq_tx.sv
// Self-checking bench for seq_tx: table of frames plus hand-written reset, busy-poke and repeat sequences.
module tb_seq_tx;
    localparam int MAX_LEN = 64;
    localparam int DIV     = 2;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       load = 1'b0;
    logic [7:0] load_data = 8'h00;
    logic [6:0] length = 7'd0;
    logic       start = 1'b0;
    logic       dataout, clkout, busy, done;

    seq_tx #(.MAX_LEN(MAX_LEN), .DIV(DIV)) dut (
        .clock(clock), .reset(reset), .load(load), .load_data(load_data),
        .length(length), .start(start), .dataout(dataout), .clkout(clkout),
        .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    bit exp_q[$];
    logic [MAX_LEN-1:0] mbuf = '0;
    int mwptr = 0;
    int w_busy, w_rise, w_done, w_done_cyc, w_first;

    typedef struct {
        int         nload;
        logic [7:0] seed;
        logic [7:0] step;
        logic [6:0] len;
        bit         accept;
    } vec_t;
    vec_t vecs[8];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic load_byte(input logic [7:0] b);
        load = 1'b1;
        load_data = b;
        @(posedge clock); #1;
        load = 1'b0;
        mbuf[mwptr*8 +: 8] = b;
        mwptr = (mwptr + 1) % (MAX_LEN / 8);
    endtask

    task automatic push_frame(input int len);
        for (int i = 0; i < len; i++) exp_q.push_back(mbuf[i]);
    endtask

    // Runs ncyc cycles after start has been driven; scoreboard pops on each clkout rise.
    task automatic watch(input int ncyc, input int drop_start, input int poke_cyc);
        bit prev_clk = 1'b0;
        bit prev_busy = 1'b0;
        int setup_at = -100;
        logic held = 1'b0;
        logic [6:0] saved_len = length;
        bit expb;
        w_busy = 0; w_rise = 0; w_done = 0; w_done_cyc = -1; w_first = -1;
        for (int c = 0; c < ncyc; c++) begin
            @(posedge clock); #1;
            if (busy) begin
                w_busy++;
                if (w_first < 0) w_first = c;
            end
            if (busy && !clkout && (!prev_busy || prev_clk)) setup_at = c;
            if (clkout && !prev_clk) begin
                w_rise++;
                chk("rise_delay", c - setup_at, DIV);
                if (exp_q.size() == 0) begin
                    chk("extra_bit", 1, 0);
                end else begin
                    expb = exp_q.pop_front();
                    chk("bit", int'(dataout), int'(expb));
                end
                held = dataout;
            end else if (clkout && prev_clk) begin
                chk("hold", int'(dataout), int'(held));
            end
            if (done) begin
                w_done++;
                w_done_cyc = c;
                chk("done_idle", int'({busy, clkout, dataout}), 0);
            end
            prev_clk = clkout;
            prev_busy = busy;
            if (c == drop_start) start = 1'b0;
            if (c == poke_cyc) begin
                load = 1'b1; load_data = 8'hFF; start = 1'b1; length = 7'd3;
            end else if (c == poke_cyc + 1) begin
                load = 1'b0; start = 1'b0; length = saved_len;
            end
        end
    endtask

    task automatic check_frame(input int bits);
        chk("busy_latency", w_first, 0);
        chk("busy_cycles", w_busy, bits * 2 * DIV);
        chk("clk_rises", w_rise, bits);
        chk("done_count", w_done, 1);
        chk("done_cycle", w_done_cyc, bits * 2 * DIV);
        chk("missing_bits", exp_q.size(), 0);
        exp_q.delete();
        mwptr = 0;
    endtask

    initial begin
        vecs[0] = '{1, 8'hA5, 8'h00, 7'd8,   1'b1};
        vecs[1] = '{0, 8'h00, 8'h00, 7'd0,   1'b0};
        vecs[2] = '{0, 8'h00, 8'h00, 7'd65,  1'b0};
        vecs[3] = '{8, 8'h3C, 8'h5B, 7'd64,  1'b1};
        vecs[4] = '{7, 8'h01, 8'h01, 7'd54,  1'b1};
        vecs[5] = '{1, 8'hC3, 8'h00, 7'd8,   1'b1};
        vecs[6] = '{0, 8'h00, 8'h00, 7'd1,   1'b1};
        vecs[7] = '{0, 8'h00, 8'h00, 7'd127, 1'b0};

        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_dataout", int'(dataout), 0);
        chk("rst_clkout", int'(clkout), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        reset = 1'b0;
        @(posedge clock); #1;

        for (int k = 0; k < 8; k++) begin
            logic [7:0] b;
            b = vecs[k].seed;
            for (int j = 0; j < vecs[k].nload; j++) begin
                load_byte(b);
                b = b + vecs[k].step;
            end
            length = vecs[k].len;
            if (vecs[k].accept) push_frame(int'(vecs[k].len));
            start = 1'b1;
            if (vecs[k].accept) begin
                watch(int'(vecs[k].len) * 2 * DIV + 12, 0, -1);
                check_frame(int'(vecs[k].len));
            end else begin
                watch(20, 0, -1);
                chk("rej_busy", w_busy, 0);
                chk("rej_rises", w_rise, 0);
                chk("rej_done", w_done, 0);
            end
        end

        // Start/load/length poked mid-frame must not disturb anything.
        load_byte(8'hA5);
        length = 7'd8;
        push_frame(8);
        start = 1'b1;
        watch(8 * 2 * DIV + 20, 0, 12);
        check_frame(8);
        length = 7'd16;
        push_frame(16);
        start = 1'b1;
        watch(16 * 2 * DIV + 12, 0, -1);
        check_frame(16);

        // Reset mid-frame: outputs clear immediately, no done, buffer zeroed.
        length = 7'd16;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (10) @(posedge clock);
        #1;
        chk("pre_rst_busy", int'(busy), 1);
        reset = 1'b1;
        #1;
        chk("mid_rst_dataout", int'(dataout), 0);
        chk("mid_rst_clkout", int'(clkout), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_done", int'(done), 0);
        for (int r = 0; r < 3; r++) begin
            @(posedge clock); #1;
            chk("rst_hold_busy", int'(busy), 0);
            chk("rst_hold_done", int'(done), 0);
        end
        reset = 1'b0;
        mbuf = '0;
        mwptr = 0;
        exp_q.delete();
        length = 7'd16;
        push_frame(16);
        start = 1'b1;
        watch(16 * 2 * DIV + 12, 0, -1);
        check_frame(16);

`ifdef SEQ_TX_REPEAT_EN
        // Start held across the first frame end: two frames back to back, one done.
        load_byte(8'hA5);
        length = 7'd8;
        push_frame(8);
        push_frame(8);
        start = 1'b1;
        watch(16 * 2 * DIV + 12, 8 * 2 * DIV, -1);
        check_frame(16);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
